// File: rtl/controller_addr_gen_if.sv
// Address stream bundle between the address generator (master) and its consumer (slave).
interface controller_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              addr_v;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              addr_ready;

  modport master (
    output addr_v,
    output addr,
    output addr_last,
    input  addr_ready
  );

  modport slave (
    input  addr_v,
    input  addr,
    input  addr_last,
    output addr_ready
  );
endinterface

// File: rtl/controller_addr_gen.sv
// Loop-nest address generator: addr = base + sum(iters[l]*stride[l]) through a 2-stage pipeline.
// Optional sticky bounds check is compiled in when ADDR_GEN_BOUNDS_CHECK_EN is defined.
module controller_addr_gen #(
  parameter int LOOP_ID_W     = 5,
  parameter int LOOP_ITER_W   = 16,
  parameter int STRIDE_W      = 16,
  parameter int ADDR_W        = 32,
  parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic                               block_done,
  input  logic                               cfg_base_v,
  input  logic [ADDR_W-1:0]                  cfg_base,
  input  logic                               cfg_stride_v,
  input  logic [STRIDE_W-1:0]                cfg_stride,
  input  logic [LOOP_ID_W-1:0]               cfg_stride_loop_id,
  input  logic                               iter_v,
  input  logic [LOOP_ITER_W*NUM_MAX_LOOPS-1:0] current_iters,
  input  logic                               iter_last,
  controller_addr_gen_if.master              aout,
  output logic                               stall,
  input  logic [ADDR_W-1:0]                  cfg_limit,
  output logic                               addr_err
);

  localparam int PROD_W = LOOP_ITER_W + STRIDE_W;

  logic [STRIDE_W-1:0] stride_q  [NUM_MAX_LOOPS];
  logic [STRIDE_W-1:0] stride_d  [NUM_MAX_LOOPS];
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                start_q;
  logic                start_rise;
  logic                en;
  logic                s1_cap;

  logic                s1_v_q, s1_v_d;
  logic                s1_last_q, s1_last_d;
  logic [ADDR_W-1:0]   s1_base_q, s1_base_d;
  logic [ADDR_W-1:0]   s1_prod_q [NUM_MAX_LOOPS];
  logic [ADDR_W-1:0]   s1_prod_d [NUM_MAX_LOOPS];

  logic                addr_v_q, addr_v_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                addr_last_q, addr_last_d;
  logic [ADDR_W-1:0]   sum;

  function automatic logic [ADDR_W-1:0] prod_trunc(
    input logic [LOOP_ITER_W-1:0] it,
    input logic [STRIDE_W-1:0]    st
  );
    logic [PROD_W-1:0] full;
    full = PROD_W'(it) * PROD_W'(st);
    return ADDR_W'(full);
  endfunction

  assign en         = ~addr_v_q | aout.addr_ready;
  assign stall      = ~en;
  assign start_rise = start & ~start_q;
  assign s1_cap     = iter_v & en;

  // A stride write in the same cycle as block_done survives; every other index clears.
  always_comb begin
    base_d = cfg_base_v ? cfg_base : base_q;
    for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
      stride_d[l] = block_done ? '0 : stride_q[l];
      if (cfg_stride_v && (int'(cfg_stride_loop_id) == l))
        stride_d[l] = cfg_stride;
    end
  end

  // Stage 1 samples the currently registered strides/base, so later writes never touch it.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_last_d = s1_last_q;
    s1_base_d = s1_base_q;
    for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
      s1_prod_d[l] = s1_prod_q[l];
      if (s1_cap)
        s1_prod_d[l] = prod_trunc(current_iters[LOOP_ITER_W*l +: LOOP_ITER_W], stride_q[l]);
    end
    if (start_rise)
      s1_v_d = s1_cap;
    else if (en)
      s1_v_d = iter_v;
    if (s1_cap) begin
      s1_last_d = iter_last;
      s1_base_d = base_q;
    end
  end

  always_comb begin
    sum = s1_base_q;
    for (int l = 0; l < NUM_MAX_LOOPS; l++)
      sum = sum + s1_prod_q[l];
  end

  always_comb begin
    addr_v_d    = addr_v_q;
    addr_d      = addr_q;
    addr_last_d = addr_last_q;
    if (start_rise)
      addr_v_d = 1'b0;
    else if (en) begin
      addr_v_d = s1_v_q;
      if (s1_v_q) begin
        addr_d      = sum;
        addr_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
        stride_q[l]  <= '0;
        s1_prod_q[l] <= '0;
      end
      base_q      <= '0;
      start_q     <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_base_q   <= '0;
      addr_v_q    <= 1'b0;
      addr_q      <= '0;
      addr_last_q <= 1'b0;
    end else begin
      stride_q    <= stride_d;
      s1_prod_q   <= s1_prod_d;
      base_q      <= base_d;
      start_q     <= start;
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      s1_base_q   <= s1_base_d;
      addr_v_q    <= addr_v_d;
      addr_q      <= addr_d;
      addr_last_q <= addr_last_d;
    end
  end

  assign aout.addr_v    = addr_v_q;
  assign aout.addr      = addr_q;
  assign aout.addr_last = addr_last_q;

`ifdef ADDR_GEN_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // A violation in the same cycle as a start edge keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (start_rise)
      err_d = 1'b0;
    if (addr_v_q && aout.addr_ready && (addr_q >= cfg_limit))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign addr_err = err_q;
`else
  logic cfg_limit_unused;
  assign cfg_limit_unused = ^cfg_limit;
  assign addr_err         = 1'b0;
`endif

endmodule

// File: tb/tb_controller_addr_gen.sv
// Randomized scoreboard bench for controller_addr_gen against an arithmetic reference model.
module tb_controller_addr_gen;
  localparam int LID_W = 5;
  localparam int IT_W  = 16;
  localparam int ST_W  = 16;
  localparam int AW    = 32;
  localparam int NL    = 32;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
  } exp_t;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start, block_done, cfg_base_v, cfg_stride_v, iter_v, iter_last;
  logic [AW-1:0]      cfg_base, cfg_limit;
  logic [ST_W-1:0]    cfg_stride;
  logic [LID_W-1:0]   cfg_stride_loop_id;
  logic [IT_W*NL-1:0] current_iters;
  logic               stall, addr_err;

  controller_addr_gen_if #(.ADDR_W(AW)) aif ();

  controller_addr_gen #(
    .LOOP_ID_W(LID_W), .LOOP_ITER_W(IT_W), .STRIDE_W(ST_W), .ADDR_W(AW), .NUM_MAX_LOOPS(NL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .block_done(block_done),
    .cfg_base_v(cfg_base_v), .cfg_base(cfg_base),
    .cfg_stride_v(cfg_stride_v), .cfg_stride(cfg_stride), .cfg_stride_loop_id(cfg_stride_loop_id),
    .iter_v(iter_v), .current_iters(current_iters), .iter_last(iter_last),
    .aout(aif), .stall(stall), .cfg_limit(cfg_limit), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            n_pass = 0;
  int            n_total = 0;
  logic [ST_W-1:0] m_stride [NL];
  logic [AW-1:0] m_base;
  logic          m_err = 1'b0;
  logic          m_start_prev = 1'b0;
  logic          flush_evt = 1'b0;
  logic          hs_over = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [AW-1:0] model_addr();
    longint unsigned acc, a, b;
    acc = m_base;
    for (int l = 0; l < NL; l++) begin
      a = current_iters[IT_W*l +: IT_W];
      b = m_stride[l];
      acc = acc + a * b;
    end
    return AW'(acc);
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) m_stride[l] = '0;
    m_base = '0;
    m_err = 1'b0;
    m_start_prev = 1'b0;
    sb.delete();
  endtask

  // One clock: sample acceptance mid-cycle, update scoreboard and model at the edge.
  task automatic step(output bit acc);
    bit   srise;
    exp_t e;
    @(negedge clk);
    acc   = iter_v && !stall;
    srise = start && !m_start_prev;
    @(posedge clk);
    flush_evt = srise;
    if (srise) sb.delete();
    if (acc) begin
      e.last = iter_last;
      e.addr = model_addr();
      sb.push_back(e);
    end
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    if (srise) m_err = 1'b0;
    if (hs_over) m_err = 1'b1;
`endif
    if (block_done) for (int l = 0; l < NL; l++) m_stride[l] = '0;
    if (cfg_stride_v) m_stride[cfg_stride_loop_id] = cfg_stride;
    if (cfg_base_v) m_base = cfg_base;
    m_start_prev = start;
    #1;
  endtask

  task automatic set_tuple(input int i0, input int i1, input logic last);
    for (int l = 0; l < NL; l++) current_iters[IT_W*l +: IT_W] = IT_W'($urandom);
    current_iters[0 +: IT_W]    = IT_W'(i0);
    current_iters[IT_W +: IT_W] = IT_W'(i1);
    iter_last = last;
  endtask

  task automatic cfg_base_w(input logic [AW-1:0] b);
    bit a;
    cfg_base_v = 1'b1; cfg_base = b;
    step(a);
    cfg_base_v = 1'b0;
  endtask

  task automatic cfg_stride_w(input int id, input int s);
    bit a;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = LID_W'(id); cfg_stride = ST_W'(s);
    step(a);
    cfg_stride_v = 1'b0;
  endtask

  // Issue the already-set tuple alone and check the address two cycles after acceptance.
  task automatic one_shot(input string name, input logic [AW-1:0] exp_addr);
    bit a;
    aif.addr_ready = 1'b1;
    iter_v = 1'b1;
    step(a);
    chk({name, "_acc"}, a, 1);
    iter_v = 1'b0;
    step(a);
    chk({name, "_v"}, aif.addr_v, 1);
    chk({name, "_addr"}, aif.addr, exp_addr);
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    iter_v = 1'b0;
    aif.addr_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step(a);
      n++;
    end
    chk("drain_done", sb.size() == 0, 1);
    step(a);
  endtask

  // Monitor: pops expectations on every accepted output and checks handshake rules.
  initial begin
    logic          pv_hold;
    logic [AW-1:0] p_addr;
    logic          p_last;
    exp_t          e;
    pv_hold = 1'b0;
    p_addr  = '0;
    p_last  = 1'b0;
    forever begin
      @(negedge clk);
      hs_over = 1'b0;
      if (resetn !== 1'b1) begin
        pv_hold = 1'b0;
        continue;
      end
      if (pv_hold && !flush_evt) begin
        chk("hold_v", aif.addr_v, 1);
        chk("hold_addr", aif.addr, p_addr);
        chk("hold_last", aif.addr_last, p_last);
      end
      chk("stall", stall, aif.addr_v && !aif.addr_ready);
      chk("addr_err", addr_err, m_err);
      if (aif.addr_v && aif.addr_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("addr", aif.addr, e.addr);
          chk("addr_last", aif.addr_last, e.last);
          hs_over = (e.addr >= cfg_limit);
        end
      end
      pv_hold = aif.addr_v && !aif.addr_ready;
      p_addr  = aif.addr;
      p_last  = aif.addr_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int k;
    int tq [3][2];
    resetn = 1'b0; start = 0; block_done = 0; cfg_base_v = 0; cfg_stride_v = 0;
    iter_v = 0; iter_last = 0; cfg_base = '0; cfg_stride = '0; cfg_stride_loop_id = '0;
    cfg_limit = '1; current_iters = '0; aif.addr_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_v", aif.addr_v, 0);
    chk("rst_addr", aif.addr, 0);
    chk("rst_addr_last", aif.addr_last, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_stall", stall, 0);
    resetn = 1'b1;

    // base 0x100, strides 4/64, iters (3,2)
    cfg_base_w(32'h100);
    cfg_stride_w(0, 4);
    cfg_stride_w(1, 64);
    set_tuple(3, 2, 0);
    one_shot("basic", 32'h18C);
    drain();

    // backpressure: tuples held by the producer until accepted
    tq = '{'{1, 0}, '{2, 0}, '{0, 1}};
    k = 0;
    aif.addr_ready = 1'b0;
    repeat (7) begin
      if (k < 3) begin set_tuple(tq[k][0], tq[k][1], 0); iter_v = 1'b1; end
      else iter_v = 1'b0;
      step(a);
      if (a) k++;
    end
    chk("bp_stall", stall, 1);
    chk("bp_v", aif.addr_v, 1);
    chk("bp_accepted", k, 2);
    aif.addr_ready = 1'b1;
    for (int n = 0; n < 10 && k < 3; n++) begin
      set_tuple(tq[k][0], tq[k][1], 0); iter_v = 1'b1;
      step(a);
      if (a) k++;
    end
    chk("bp_all_accepted", k, 3);
    drain();

    // addr_last tracks the tuple it was issued with
    iter_v = 1'b1;
    set_tuple(1, 1, 0); step(a);
    set_tuple(2, 1, 0); step(a);
    set_tuple(7, 1, 1); step(a);
    set_tuple(0, 0, 0); step(a);
    drain();

    // start edge drops in-flight tuples but accepts the one presented with it
    iter_v = 1'b1;
    set_tuple(1, 0, 0); step(a);
    set_tuple(2, 0, 0); step(a);
    set_tuple(3, 0, 0); start = 1'b1; step(a);
    chk("flush_acc", a, 1);
    iter_v = 1'b0;
    step(a);
    start = 1'b0;
    drain();

    // block_done clears strides, base survives reconfiguration
    block_done = 1'b1; step(a); block_done = 1'b0;
    cfg_base_w(32'h40);
    set_tuple(5, 5, 0);
    one_shot("blkdone", 32'h40);
    drain();
    block_done = 1'b1; cfg_stride_v = 1'b1; cfg_stride_loop_id = 5'd2; cfg_stride = 16'd8;
    step(a);
    block_done = 1'b0; cfg_stride_v = 1'b0;
    set_tuple(9, 9, 0);
    current_iters[2*IT_W +: IT_W] = 16'd3;
    one_shot("blk_wr_wins", 32'h58);
    drain();

    // bounds check
    block_done = 1'b1; step(a); block_done = 1'b0;
    cfg_base_w(32'h100);
    cfg_stride_w(0, 4);
    cfg_stride_w(1, 64);
    cfg_limit = 32'h180;
    set_tuple(3, 2, 0);
    one_shot("bounds", 32'h18C);
    step(a);
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    chk("err_set", addr_err, 1);
    repeat (3) step(a);
    chk("err_sticky", addr_err, 1);
    start = 1'b1; step(a); start = 1'b0;
    chk("err_cleared", addr_err, 0);
`else
    chk("err_tied", addr_err, 0);
    repeat (3) step(a);
    chk("err_tied_later", addr_err, 0);
`endif
    step(a);
    cfg_limit = '1;
    drain();

    // reset with two tuples in flight
    iter_v = 1'b1;
    set_tuple(1, 0, 0); step(a);
    set_tuple(2, 0, 0); step(a);
    iter_v = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_addr_v", aif.addr_v, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_addr", aif.addr, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) begin
      step(a);
      chk("post_rst_idle", aif.addr_v, 0);
    end
    cfg_base_w(32'h20);
    cfg_stride_w(1, 2);
    set_tuple(4, 6, 0);
    one_shot("post_rst", 32'h2C);
    drain();

    // randomized traffic
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    cfg_limit = $urandom;
`endif
    for (int c = 0; c < 1500; c++) begin
      iter_v         = ($urandom_range(0, 3) != 0);
      iter_last      = ($urandom_range(0, 7) == 0);
      aif.addr_ready = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < NL; l++) current_iters[IT_W*l +: IT_W] = IT_W'($urandom);
      block_done     = ($urandom_range(0, 49) == 0);
      cfg_stride_v   = ($urandom_range(0, 4) == 0);
      cfg_stride_loop_id = LID_W'($urandom_range(0, NL - 1));
      cfg_stride     = ST_W'($urandom);
      cfg_base_v     = ($urandom_range(0, 19) == 0);
      cfg_base       = $urandom;
      if ($urandom_range(0, 29) == 0) start = ~start;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
      if ($urandom_range(0, 99) == 0) cfg_limit = $urandom;
`endif
      step(a);
    end
    block_done = 0; cfg_stride_v = 0; cfg_base_v = 0; start = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/controller_addr_gen.md
CONTROLLER_ADDR_GEN -- requirements
Module: controller_addr_gen

Interface
REQ-001 SHALL have parameter LOOP_ID_W, default 5, loop index width.
REQ-002 SHALL have parameter LOOP_ITER_W, default 16, per-loop iteration width.
REQ-003 SHALL have parameter STRIDE_W, default 16, per-loop stride width, unsigned.
REQ-004 SHALL have parameter ADDR_W, default 32, output address width.
REQ-005 SHALL have parameter NUM_MAX_LOOPS, default 1<<LOOP_ID_W, number of loop levels.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit, level start from the loop FSM.
REQ-009 SHALL have port block_done, input, 1 bit, clears stride configuration.
REQ-010 SHALL have ports cfg_base_v (input, 1) and cfg_base (input, ADDR_W), base address load.
REQ-011 SHALL have ports cfg_stride_v (input, 1), cfg_stride (input, STRIDE_W) and cfg_stride_loop_id (input, LOOP_ID_W), stride write.
REQ-012 SHALL have port iter_v, input, 1 bit, current_iters valid this cycle (FSM advancing).
REQ-013 SHALL have port current_iters, input, LOOP_ITER_W*NUM_MAX_LOOPS, loop l in slice [LOOP_ITER_W*l +: LOOP_ITER_W].
REQ-014 SHALL have port iter_last, input, 1 bit, marks the final iteration tuple (FSM done).
REQ-015 SHALL have port addr_ready, input, 1 bit, downstream accept.
REQ-016 SHALL have ports addr_v (output, 1), addr (output, ADDR_W) and addr_last (output, 1), address stream.
REQ-017 SHALL have port stall, output, 1 bit, backpressure to the loop FSM.
REQ-018 SHALL have ports cfg_limit (input, ADDR_W) and addr_err (output, 1), bounds check.

Function
REQ-019 SHALL compute addr = base + sum over l of iters[l]*stride[l], modulo 2^ADDR_W; each product is truncated to ADDR_W before summation.
REQ-020 SHALL store stride[l] on cfg_stride_v at index cfg_stride_loop_id; an unwritten stride reads as 0.
REQ-021 SHALL clear all strides to 0 on block_done; when cfg_stride_v and block_done coincide, the write wins for that index and all others clear.
REQ-022 SHALL latch base on cfg_base_v; base is not cleared by block_done.
REQ-023 SHALL be a 2-stage pipeline: S1 registers per-loop products, S2 registers sum+base; a tuple accepted at cycle t appears on addr at t+2 when not stalled.
REQ-024 SHALL advance both stages only when en = ~addr_v | addr_ready; S1 captures a tuple only when iter_v && en.
REQ-025 SHALL drive stall = ~en, combinationally.
REQ-026 SHALL hold addr, addr_v and addr_last stable while addr_v && ~addr_ready.
REQ-027 SHALL carry iter_last alongside its tuple and emit it as addr_last with the matching address.
REQ-028 SHALL flush both pipeline valids on a start rising edge; in-flight tuples are dropped, and a tuple presented in that same cycle is accepted.
REQ-029 SHALL use the stride and base values in effect at S1 capture; a later reconfiguration does not alter in-flight tuples.
REQ-030 SHALL ignore current_iters slices for loops whose stride is 0, with no overflow side effects.

Reset
REQ-031 SHALL on resetn low asynchronously clear: addr_v=0, addr=0, addr_last=0, addr_err=0, all strides=0, base=0, pipeline valids=0.
REQ-032 SHALL hold stall=0 during reset, since addr_v=0 there.
REQ-033 SHALL discard in-flight tuples on reset asserted mid-operation; the first address after release comes only from a new iter_v.

Configuration
REQ-034 SHALL implement bounds checking only when macro ADDR_GEN_BOUNDS_CHECK_EN is defined.
REQ-035 SHALL with the macro defined set addr_err sticky high when an emitted addr (addr_v && addr_ready) is >= cfg_limit, and clear it only on reset or a start rising edge.
REQ-036 SHALL without the macro tie addr_err to 0, ignore cfg_limit, and keep the ports present.

Verification
REQ-037 SHALL cover: base=0x100, stride[0]=4, stride[1]=64, iters (3,2) with addr_ready=1 -> addr=0x18C two cycles after iter_v.
REQ-038 SHALL cover: addr_ready=0 for 5 cycles with addr_v=1 -> addr held, stall=1, no tuple lost; 3 queued tuples emerge in order after release.
REQ-039 SHALL cover: iter_last on tuple (7,1) -> addr_last=1 only with that tuple's address.
REQ-040 SHALL cover: block_done, then iters (5,5) with base=0x40 -> addr=0x40.
REQ-041 SHALL cover: resetn low while 2 tuples are in flight -> addr_v=0 immediately, no output after release until a new iter_v.
REQ-042 SHALL cover, with ADDR_GEN_BOUNDS_CHECK_EN defined: cfg_limit=0x180 and addr=0x18C accepted -> addr_err=1, held until a start edge.
